// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and address-mux codes for the matmul read-out path

package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } unload_state_t;

    // Data-memory port-1 address mux codes, shared with the top-level mux
    localparam logic [1:0] SEL_CORE     = 2'd0;
    localparam logic [1:0] SEL_TB_WRITE = 2'd1;
    localparam logic [1:0] SEL_READ     = 2'd2;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - 2-entry synchronous FIFO absorbing data-memory read latency

module result_fifo #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = i_pop & (r_count != 2'd0);
    // A push into a full FIFO is accepted only when the head leaves in the same cycle
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/result_unloader.sv
// rtl/result_unloader.sv - reads matrix C row-major from data memory and streams it out

module result_unloader
    import matmul_pkg::unload_state_t;
    import matmul_pkg::ST_IDLE;
    import matmul_pkg::ST_READ;
    import matmul_pkg::ST_DRAIN;
    import matmul_pkg::ST_DONE;
#(
    parameter int         DATA_W   = 16,
    parameter int         ADDR_W   = 16,
    parameter logic [1:0] SEL_READ = matmul_pkg::SEL_READ,
    parameter logic [1:0] SEL_CORE = matmul_pkg::SEL_CORE
) (
    input  logic              clk,
    input  logic              RESET_N,
    input  logic              end_i,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       rows,
    input  logic [15:0]       cols,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        addr_mux_select,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eol,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int FW = DATA_W + 2;

    unload_state_t     r_state;
    logic              r_end_q;
    logic              r_rise;
    logic [ADDR_W-1:0] r_base;
    logic [15:0]       r_cols;
    logic [15:0]       r_total;
    logic [15:0]       r_idx;
    logic [15:0]       r_col;
    logic              r_inflight;
    logic              r_if_eol;
    logic              r_if_last;
    logic [1:0]        r_mux_sel;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_busy;
    logic              r_done;

    logic [31:0]       w_prod;
    logic [15:0]       w_total;
    logic [2:0]        w_occ;
    logic              w_pop;
    logic              w_issue;
    logic              w_col_end;
    logic              w_idx_end;
    logic              w_full;
    logic              w_empty;
    logic [1:0]        w_count;
    logic [FW-1:0]     w_head;

    assign w_prod  = 32'(rows) * 32'(cols);
    assign w_total = (w_prod > 32'd65535) ? 16'hFFFF : w_prod[15:0];

    assign w_pop     = out_valid & out_ready;
    // A slot freed by this cycle's pop may be refilled by this cycle's issue
    assign w_occ     = {1'b0, w_count} + {2'b00, r_inflight};
    assign w_issue   = (r_state == ST_READ) && (w_occ < (3'd2 + {2'b00, w_pop}));
    assign w_col_end = (r_col == r_cols - 16'd1);
    assign w_idx_end = (r_idx == r_total - 16'd1);

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_IDLE;
            r_end_q    <= 1'b0;
            r_rise     <= 1'b0;
            r_base     <= '0;
            r_cols     <= '0;
            r_total    <= '0;
            r_idx      <= '0;
            r_col      <= '0;
            r_inflight <= 1'b0;
            r_if_eol   <= 1'b0;
            r_if_last  <= 1'b0;
            r_mux_sel  <= SEL_CORE;
            r_rd_addr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_end_q    <= end_i;
            r_rise     <= end_i & ~r_end_q & (r_state == ST_IDLE);
            r_done     <= 1'b0;
            r_inflight <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_rise) begin
                        r_base  <= base_addr;
                        r_cols  <= cols;
                        r_total <= w_total;
                        r_busy  <= 1'b1;
                        if (w_total == 16'd0) begin
                            r_state <= ST_DONE;
                        end else begin
                            // The latch cycle also issues word 0 to keep the start latency at two cycles
                            r_rd_addr  <= base_addr;
                            r_inflight <= 1'b1;
                            r_if_eol   <= (cols == 16'd1);
                            r_if_last  <= (w_total == 16'd1);
                            r_idx      <= 16'd1;
                            r_col      <= (cols == 16'd1) ? 16'd0 : 16'd1;
                            r_mux_sel  <= SEL_READ;
                            r_state    <= (w_total == 16'd1) ? ST_DRAIN : ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (w_issue) begin
                        r_rd_addr  <= r_base + ADDR_W'(r_idx);
                        r_inflight <= 1'b1;
                        r_if_eol   <= w_col_end;
                        r_if_last  <= w_idx_end;
                        r_idx      <= r_idx + 16'd1;
                        r_col      <= w_col_end ? 16'd0 : r_col + 16'd1;
                        if (w_idx_end) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!r_inflight && (w_empty || (w_count == 2'd1 && w_pop))) begin
                        r_mux_sel <= SEL_CORE;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    result_fifo #(.W(FW)) u_fifo (
        .clk     (clk),
        .rst_n   (RESET_N),
        .i_push  (r_inflight),
        .i_wdata ({mem_rdata, r_if_eol, r_if_last}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign out_valid       = ~w_empty;
    assign out_data        = w_head[FW-1:2];
    assign out_eol         = w_head[1];
    assign out_last        = w_head[0];
    assign addr_mux_select = r_mux_sel;
    assign rd_addr         = r_rd_addr;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_result_unloader.sv
// tb/tb_result_unloader.sv - scoreboard bench for result_unloader

module tb_result_unloader;

    typedef struct packed {
        logic [15:0] d;
        logic        eol;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        RESET_N = 1'b0;
    logic        end_i = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] rows = '0;
    logic [15:0] cols = '0;
    logic [15:0] mem_rdata;
    logic [1:0]  addr_mux_select;
    logic [15:0] rd_addr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_eol;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [15:0] tb_mem [0:65535];
    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[rd_addr];

    result_unloader dut (
        .clk             (clk),
        .RESET_N         (RESET_N),
        .end_i           (end_i),
        .base_addr       (base_addr),
        .rows            (rows),
        .cols            (cols),
        .mem_rdata       (mem_rdata),
        .addr_mux_select (addr_mux_select),
        .rd_addr         (rd_addr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_eol         (out_eol),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (RESET_N && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_word", {16'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                mon_e = q.pop_front();
                check("word_data", {16'h0, out_data}, {16'h0, mon_e.d});
                check("word_eol",  {31'h0, out_eol},  {31'h0, mon_e.eol});
                check("word_last", {31'h0, out_last}, {31'h0, mon_e.last});
            end
        end
    end

    task automatic run(input logic [15:0] b, input logic [15:0] nr, input logic [15:0] nc,
                       input logic [3:0] pat, input logic hold, input int abort_at,
                       input int exp_addr_c, input int exp_valid_c, input int exp_done_c);
        int          n;
        int          c;
        int          accepted;
        int          c_addr;
        int          c_valid;
        int          c_done;
        logic        ahead_bad;
        logic        saw_valid;
        logic        saw_mux;
        logic        aborted;
        logic [15:0] issued;
        logic [15:0] aq[$];
        n = int'(nr) * int'(nc);
        for (int k = 0; k < n; k++) begin
            q.push_back('{d: tb_mem[16'(b + 16'(k))], eol: ((k % int'(nc)) == int'(nc) - 1),
                          last: (k == n - 1)});
        end
        @(posedge clk);
        #1;
        base_addr = b;
        rows = nr;
        cols = nc;
        end_i = 1'b1;
        out_ready = pat[0];
        c = 0; accepted = 0; c_addr = -1; c_valid = -1; c_done = -1;
        ahead_bad = 0; saw_valid = 0; saw_mux = 0; aborted = 0;
        while (c < 400) begin
            @(negedge clk);
            if (addr_mux_select == 2'd2) begin
                saw_mux = 1;
                if (c_addr < 0) c_addr = c;
                if (aq.size() == 0 || rd_addr != aq[$]) aq.push_back(rd_addr);
                issued = rd_addr - b + 16'd1;
                if (int'(issued) > accepted + 2) ahead_bad = 1;
            end
            if (out_valid) begin
                saw_valid = 1;
                if (c_valid < 0) c_valid = c;
            end
            if (out_valid && out_ready) accepted++;
            if (done) begin
                c_done = c;
                break;
            end
            if (abort_at > 0 && accepted == abort_at) begin
                aborted = 1;
                break;
            end
            @(posedge clk);
            #1;
            c++;
            if (!hold) end_i = 1'b0;
            out_ready = pat[c[1:0]];
        end
        if (aborted) begin
            #2 RESET_N = 1'b0;
            #1;
            check("rst_async_flags", {27'h0, out_valid, busy, done, out_eol, out_last}, 32'h0);
            check("rst_async_mux", {30'h0, addr_mux_select}, 32'h0);
            check("rst_async_rd_addr", {16'h0, rd_addr}, 32'h0);
            check("rst_async_out_data", {16'h0, out_data}, 32'h0);
            q.delete();
            end_i = 1'b0;
            @(posedge clk);
            #1 RESET_N = 1'b1;
            saw_valid = 0;
            saw_mux = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (out_valid || busy) saw_valid = 1;
                if (addr_mux_select != 2'd0) saw_mux = 1;
            end
            check("rst_release_quiet", {31'h0, saw_valid}, 32'h0);
            check("rst_release_mux", {31'h0, saw_mux}, 32'h0);
        end else begin
            check("done_seen", {31'h0, c_done >= 0}, 32'h1);
            if (exp_done_c >= 0) check("done_cycle", c_done, exp_done_c);
            if (n > 0) begin
                check("first_addr_cycle", c_addr, exp_addr_c);
                check("first_valid_cycle", c_valid, exp_valid_c);
                check("addr_count", aq.size(), n);
                for (int k = 0; k < n && k < aq.size(); k++) begin
                    check("addr_seq", {16'h0, aq[k]}, {16'h0, 16'(b + 16'(k))});
                end
                check("reads_ahead_le2", {31'h0, ahead_bad}, 32'h0);
            end else begin
                check("zero_no_valid", {31'h0, saw_valid}, 32'h0);
                check("zero_mux_core", {31'h0, saw_mux}, 32'h0);
            end
            check("all_words_out", q.size(), 0);
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(negedge clk);
            check("done_one_cycle", {31'h0, done}, 32'h0);
            check("idle_busy", {31'h0, busy}, 32'h0);
            check("idle_mux", {30'h0, addr_mux_select}, 32'h0);
        end
    endtask

    initial begin
        logic saw_busy;
        for (int i = 0; i < 65536; i++) tb_mem[i] = 16'(i * 7 + 3) ^ 16'h5A00;
        tb_mem[16'h0040] = 16'd11;
        tb_mem[16'h0041] = 16'd22;
        tb_mem[16'h0042] = 16'd33;
        tb_mem[16'h0043] = 16'd44;

        #3;
        check("reset_flags", {27'h0, out_valid, busy, done, out_eol, out_last}, 32'h0);
        check("reset_mux", {30'h0, addr_mux_select}, 32'h0);
        check("reset_rd_addr", {16'h0, rd_addr}, 32'h0);
        check("reset_out_data", {16'h0, out_data}, 32'h0);
        repeat (2) @(posedge clk);
        #1 RESET_N = 1'b1;

        // basic 2x2, full throughput
        run(16'h0040, 16'd2, 16'd2, 4'b1111, 1'b0, 0, 2, 3, 8);
        // 3x3 with ready pattern 1,0,0,1
        run(16'h0080, 16'd3, 16'd3, 4'b1001, 1'b0, 0, 2, 3, -1);
        // zero rows
        run(16'h0100, 16'd0, 16'd5, 4'b1111, 1'b0, 0, -1, -1, 3);
        // address wrap
        run(16'hFFFE, 16'd1, 16'd4, 4'b1111, 1'b0, 0, 2, 3, 8);
        // reset after 3 of 16 words
        run(16'h0300, 16'd4, 16'd4, 4'b1111, 1'b0, 3, -1, -1, -1);
        // end_i held high across DONE, then a fresh edge
        run(16'h0200, 16'd1, 16'd3, 4'b1111, 1'b1, 0, 2, 3, 7);
        saw_busy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy || out_valid) saw_busy = 1;
        end
        check("level_no_retrigger", {31'h0, saw_busy}, 32'h0);
        @(posedge clk);
        #1 end_i = 1'b0;
        repeat (2) @(posedge clk);
        run(16'h0040, 16'd2, 16'd2, 4'b1111, 1'b0, 0, 2, 3, 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_unloader.md
# result_unloader

Downstream read-out stage for the multicore matrix multiplier. After core 0 raises `END`, it takes over the data-memory test-read address path (`addr_mux_select`/`ar_in`) and reads the result matrix C row-major from data memory. It streams each word out over a valid/ready interface. A 2-entry buffer absorbs the memory read latency so consumer back-pressure never loses a word.

## Interface
Parameters:
- `DATA_W`, 16: data-memory word width
- `ADDR_W`, 16: data-memory address width
- `SEL_READ`, 2'd2: `addr_mux_select` code that routes the read address (`ar_in`) to memory port 1
- `SEL_CORE`, 2'd0: `addr_mux_select` code that gives port 1 back to core 0

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, shared with cores and data memory
- `RESET_N` in 1: asynchronous active-low reset
- `end_i` in 1: `END` from core 0, level
- `base_addr` in ADDR_W: address of C[0][0]
- `rows` in 16: number of rows of C
- `cols` in 16: number of columns of C
- `mem_rdata` in DATA_W: data-memory port-1 read data (`dmem_in`)
- `addr_mux_select` out 2: drives the data-memory address mux
- `rd_addr` out ADDR_W: read address, drives `ar_in`
- `out_valid` out 1: `out_data` holds a valid word
- `out_ready` in 1: consumer accepts the word
- `out_data` out DATA_W: result word
- `out_eol` out 1: word is the last of its row
- `out_last` out 1: word is the last of the matrix
- `busy` out 1: unload in progress
- `done` out 1: one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - Register `end_i`.
  - On a rising edge (`end_i`=1 and previous value 0), latch `base_addr`, `rows` and `cols`.
  - If `rows`=0 or `cols`=0, go to DONE and emit no words; otherwise go to READ.
- READ:
  - Issue one read per cycle while (buffer occupancy + in-flight reads) < 2.
  - Issued address = latched base + issue index, 16-bit, wrapping mod 2^16.
  - Issue index counts 0 .. rows*cols-1. The product is computed at 32 bits; a product above 65535 saturates at 65535 words.
  - After the final issue, go to DRAIN.
- DRAIN: wait until the in-flight read has landed and the buffer is empty, then go to DONE.
- DONE: assert `done` for one cycle, then return to IDLE. A new unload needs a fresh rising edge of `end_i`; a level still high does not retrigger.
- Output tagging:
  - A row/column counter pair travels with each issued read.
  - `out_eol`=1 when col = cols-1.
  - `out_last`=1 on the final word.
- Mux control: `addr_mux_select`=SEL_READ whenever state is READ or DRAIN; SEL_CORE otherwise.
- Word transfer: a word transfers when `out_valid` & `out_ready`. `out_data`, `out_eol` and `out_last` stay stable while `out_valid`=1 and `out_ready`=0.
- An `end_i` rising edge during READ/DRAIN/DONE is ignored.

## Timing
- Data memory read latency is 1 cycle: address at edge t, `mem_rdata` captured at edge t+1.
- Latencies:
  - `end_i` rising edge to first `rd_addr`: 2 cycles (edge detect, then latch).
  - First `rd_addr` to first `out_valid`: 1 cycle.
- Throughput: 1 word/cycle with `out_ready` held high.
- Back-pressure: stall after at most 2 buffered words; no word dropped or duplicated.
- `busy`: high from the cycle after the edge is detected through the DONE cycle.
- Reset values: state IDLE; `addr_mux_select`=SEL_CORE; `rd_addr`=0; `out_valid`, `out_eol`, `out_last`, `busy`, `done` = 0; `out_data`=0; buffer empty.
- Reset asserted mid-unload: all outputs return to reset values immediately (asynchronous). The in-flight read is discarded and any partial stream is abandoned.
- Simultaneous buffer push and pop when full: allowed, occupancy stays 2.

## Structure
- Shared package `matmul_pkg` holds:
  - The state enum.
  - The mux select constants `SEL_CORE`, `SEL_READ`, and the code for the test-bench write path. These are shared with the top-level address mux.
- Sub-module `result_fifo`: a 2-entry synchronous FIFO, DATA_W+2 bits wide (data, eol, last), with push/pop/full/empty and asynchronous active-low reset.

## Test plan
- Basic 2x2: `rows`=2, `cols`=2, `base_addr`=0x0040, memory 0x40..0x43 = 11,22,33,44, `out_ready`=1.
  - Expect 11,22,33,44 on consecutive cycles.
  - `out_eol` on 22 and 44; `out_last` on 44.
  - `done` pulse 1 cycle after 44; `addr_mux_select` back to 0.
- Back-pressure 3x3: `out_ready` toggles 1,0,0,1 repeating.
  - Expect all 9 words in order, no duplicates.
  - `rd_addr` never more than 2 ahead of accepted words.
- Zero dimension: `rows`=0, `cols`=5, `end_i` pulses.
  - Expect no `out_valid`, `done` 3 cycles after the edge, `addr_mux_select` stays 0.
- Address wrap: `base_addr`=0xFFFE, 1x4.
  - Expect reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-stream: `RESET_N` low after 3 of 16 words.
  - Expect all outputs zero in the same cycle.
  - After release, no output until a new `end_i` edge.
- Level hold: `end_i` held high across DONE.
  - Expect exactly one unload.
  - A second unload starts only after `end_i` falls and rises again.
